// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial W-bit subtractor: diff = a - b (mod 2^W), one bit per clock,
//   LSB first. Each bit goes through a full-adder cell fed with a_i, ~b_i and
//   the running carry. The carry is seeded to 1, so the cell computes
//   a + ~b + 1.
//
//   Handshake:
//     - A start seen in IDLE loads the operands (edge 0).
//     - W RUN cycles follow, with busy high.
//     - One DONE cycle follows, with done high.
//   Results change only on the edge that completes the last bit. They then
//   hold until the next operation completes.
//
// Ports
//   clk         in   1  clock, all state on posedge
//   rst_n       in   1  asynchronous active-low reset
//   start       in   1  request, honoured in IDLE (and in DONE, see below)
//   a           in   W  minuend, captured when start is accepted
//   b           in   W  subtrahend, captured when start is accepted
//   busy        out  1  high while the bits are being processed
//   done        out  1  one-cycle pulse; results valid from this cycle
//   diff        out  W  a - b modulo 2^W
//   borrow_out  out  1  1 when a < b (unsigned)
//   ovf         out  1  signed overflow of a - b
//
// Optional feature
//   SERSUB_SIGNED_OVF_EN: when defined, adds the ovf port and its register.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out
`ifdef SERSUB_SIGNED_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_a_sh;
  logic [W-1:0]  r_b_sh;
  // Result bits collected so far. The newest bit always enters at the top.
  // After W-1 bits, r_work plus the final sum bit form the whole result.
  logic [W-2:0]  r_work;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_diff;
  logic          r_borrow;
`ifdef SERSUB_SIGNED_OVF_EN
  logic          r_ovf;
`endif

  logic         w_a_bit;
  logic         w_nb_bit;
  logic         w_sum;
  logic         w_cout;
  logic         w_last;
  logic [W-1:0] w_work_next;

  // Full-adder cell on (a_i, ~b_i, carry).
  assign w_a_bit     = r_a_sh[0];
  assign w_nb_bit    = ~r_b_sh[0];
  assign w_sum       = w_a_bit ^ w_nb_bit ^ r_carry;
  assign w_cout      = (w_a_bit & w_nb_bit) | (w_a_bit & r_carry) | (w_nb_bit & r_carry);
  assign w_last      = (r_cnt == CW'(W - 1));
  assign w_work_next = {w_sum, r_work};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_work   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_work  <= w_work_next[W-1:1];
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff   <= w_work_next;
            // The cell adds ~b + 1, so a missing final carry means a borrow.
            r_borrow <= ~w_cout;
`ifdef SERSUB_SIGNED_OVF_EN
            // r_carry is the carry into the MSB; w_cout is the carry out of it.
            r_ovf    <= r_carry ^ w_cout;
`endif
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // A start held high through DONE is taken on the edge that leaves
          // DONE. This sustains one operation per W+1 cycles.
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
`ifdef SERSUB_SIGNED_OVF_EN
  assign ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Drives directed and random subtractions into serial_subtractor.
//
//   Scoreboard flow:
//     - Each accepted start pushes the arithmetic expectation into a queue.
//     - A monitor pops the queue on every done pulse and compares.
//     - The monitor also checks every cycle that the held outputs match the
//       last completed result.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERSUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERSUB_SIGNED_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_expected = 0;
  int   n_seen = 0;

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   ua, ub, sa, sb, sd;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sd = sa - sb;
    e.av = av;
    e.bv = bv;
    e.d  = W'((ua - ub + (1 << W)) % (1 << W));
    e.br = (ua < ub);
    e.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] held_d = '0;
  logic         held_b = 1'b0;
  logic         held_o = 1'b0;
  int           busy_run = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_d   = '0;
      held_b   = 1'b0;
      held_o   = 1'b0;
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        n_seen++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
        end else begin
          e = q.pop_front();
          held_d = e.d;
          held_b = e.br;
          held_o = e.ov;
          check("busy_cycles", busy_run, W);
          $display("txn a=0x%02h b=0x%02h diff=0x%02h borrow=%0b (exp 0x%02h %0b)",
                   e.av, e.bv, diff, borrow_out, e.d, e.br);
        end
        busy_run = 0;
      end
    end
    check("diff", diff, held_d);
    check("borrow_out", borrow_out, held_b);
`ifdef SERSUB_SIGNED_OVF_EN
    check("ovf", ovf, held_o);
`endif
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    q.push_back(model(av, bv));
    n_expected++;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Called on a negedge; n0 = index of the last posedge since acceptance.
  task automatic wait_done(input int n0);
    int n;
    n = n0;
    while (!done && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done at %0d", n, W);
    end else begin
      check("latency", n, W);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    // Directed cases
    issue(8'd5, 8'd3);    wait_done(0);
    issue(8'd3, 8'd5);    wait_done(0);
    issue(8'd0, 8'd0);    wait_done(0);
    issue(8'hFF, 8'h01);  wait_done(0);
    issue(8'h80, 8'h01);  wait_done(0);
    issue(8'h7F, 8'hFF);  wait_done(0);

    // start pulsed at edge 3 of a running op must be ignored
    issue(8'd9, 8'd4);
    repeat (2) @(negedge clk);
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3);
    repeat (4) @(negedge clk);

    // reset at edge 4 of a running op: outputs clear at once, no done
    issue(8'hC8, 8'h11);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_diff", diff, 0);
    check("arst_borrow", borrow_out, 0);
`ifdef SERSUB_SIGNED_OVF_EN
    check("arst_ovf", ovf, 0);
`endif
    n_expected -= q.size();
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(8'd7, 8'd2);
    wait_done(0);

    // start held high: next op accepted at edge W+1
    @(negedge clk);
    a = 8'h40;
    b = 8'h90;
    start = 1'b1;
    @(posedge clk);
    q.push_back(model(8'h40, 8'h90));
    n_expected++;
    @(negedge clk);
    a = 8'h22;
    b = 8'h21;
    wait_done(0);
    @(posedge clk);
    q.push_back(model(8'h22, 8'h21));
    n_expected++;
    @(negedge clk);
    start = 1'b0;
    wait_done(0);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      issue(W'($urandom), W'($urandom));
      wait_done(0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("done_count", n_seen, n_expected);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
